// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and helpers for the radix-4 Booth multiplier:
//                sequencer state encoding, Booth digit encoding and the
//                3-bit group to digit decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Radix-4 Booth digits {-2,-1,0,+1,+2}
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } digit_e;

    // Group bits are {b[2i+1], b[2i], b[2i-1]}
    function automatic digit_e digit_of(input logic [2:0] grp);
        digit_e d;
        case (grp)
            3'b001, 3'b010: d = P1;
            3'b011:         d = P2;
            3'b100:         d = M2;
            3'b101, 3'b110: d = M1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_gen
//  Description : Combinational radix-4 Booth partial-product generator.
//                pp is |digit|*A, bitwise inverted for negative digits;
//                neg_cin supplies the +1 that completes the negation, so
//                pp + neg_cin == digit*A in DW+3 bit two's complement.
//  Ports       : encode  [2:0]    Booth group {b[2i+1], b[2i], b[2i-1]}
//                a_ext   [DW+1:0] extended multiplicand
//                pp      [DW+2:0] partial product before the +1
//                neg_cin          carry-in for negative digits
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [2:0]    encode,
    input  logic [DW+1:0] a_ext,
    output logic [DW+2:0] pp,
    output logic          neg_cin
);

    logic [DW+2:0] w_a_wide;
    logic [DW+2:0] w_mag;

    // One extra sign bit so that 2*A never overflows
    assign w_a_wide = {a_ext[DW+1], a_ext};

    always_comb begin
        w_mag   = '0;
        neg_cin = 1'b0;
        case (digit_of(encode))
            P1:      w_mag = w_a_wide;
            P2:      w_mag = {w_a_wide[DW+1:0], 1'b0};
            M1: begin
                w_mag   = w_a_wide;
                neg_cin = 1'b1;
            end
            M2: begin
                w_mag   = {w_a_wide[DW+1:0], 1'b0};
                neg_cin = 1'b1;
            end
            default: w_mag = '0;
        endcase
    end

    assign pp = neg_cin ? ~w_mag : w_mag;

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq
//  Description : Iterative radix-4 Booth multiplier. One Booth group of B is
//                consumed per cycle through a single shared partial-product
//                generator; K = DW/2+1 groups cover both signed and unsigned
//                operands (the top group supplies the unsigned correction).
//  Ports       : clk, rst            clock, synchronous active-high reset
//                flush               synchronous abort of any transaction
//                in_valid/in_ready   operand handshake (ready only in IDLE)
//                in_signed,in_a,in_b operand pair and signedness
//                out_valid/out_ready product handshake (valid only in DONE)
//                out_prod [2*DW]     product, held stable while in DONE
//                busy                high in RUN or DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_prod,
    output logic            busy
);

    localparam int K  = DW / 2 + 1;
    localparam int CW = $clog2(K + 1);
    localparam int AW = DW + 2;
    localparam int PW = 2 * DW;

    state_e          r_state_q, w_state_d;
    logic [CW-1:0]   r_cnt_q,   w_cnt_d;
    logic [AW-1:0]   r_a_q,     w_a_d;
    // Multiplier with b[-1] appended at the LSB; shifts right two bits per group
    logic [AW:0]     r_b_q,     w_b_d;
    logic [PW-1:0]   r_acc_q,   w_acc_d;
    logic [PW-1:0]   r_prod_q,  w_prod_d;

    logic [AW:0]     w_pp;
    logic            w_neg_cin;
    logic [PW-1:0]   w_pp_ext;
    logic [PW-1:0]   w_term;
    logic [PW-1:0]   w_sum;
    logic            w_last;

    booth_pp_gen #(.DW(DW)) u_pp_gen (
        .encode  (r_b_q[2:0]),
        .a_ext   (r_a_q),
        .pp      (w_pp),
        .neg_cin (w_neg_cin)
    );

    // Sign-extend the partial product, add the negation carry, weight by 4^i
    assign w_pp_ext = {{(PW-AW-1){w_pp[AW]}}, w_pp};
    assign w_term   = (w_pp_ext + {{(PW-1){1'b0}}, w_neg_cin}) << {r_cnt_q, 1'b0};
    assign w_sum    = r_acc_q + w_term;
    assign w_last   = (r_cnt_q == CW'(K - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic; flush overrides every handshake
    always_comb begin
        w_state_d = r_state_q;
        if (flush) begin
            w_state_d = IDLE;
        end else begin
            case (r_state_q)
                IDLE:    if (in_valid)  w_state_d = RUN;
                RUN:     if (w_last)    w_state_d = DONE;
                DONE:    if (out_ready) w_state_d = IDLE;
                default:                w_state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = (r_state_q == IDLE);
        out_valid = (r_state_q == DONE);
        busy      = (r_state_q == RUN) || (r_state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_a_d    = r_a_q;
        w_b_d    = r_b_q;
        w_acc_d  = r_acc_q;
        w_prod_d = r_prod_q;
        if (flush) begin
            w_cnt_d = '0;
            w_acc_d = '0;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (in_valid) begin
                        w_a_d   = {{2{in_signed & in_a[DW-1]}}, in_a};
                        w_b_d   = {{2{in_signed & in_b[DW-1]}}, in_b, 1'b0};
                        w_acc_d = '0;
                        w_cnt_d = '0;
                    end
                end
                RUN: begin
                    w_acc_d = w_sum;
                    w_cnt_d = r_cnt_q + 1'b1;
                    w_b_d   = {2'b00, r_b_q[AW:2]};
                    // Only the completed sum ever reaches the output register
                    if (w_last) begin
                        w_prod_d = w_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_a_q    <= '0;
            r_b_q    <= '0;
            r_acc_q  <= '0;
            r_prod_q <= '0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_a_q    <= w_a_d;
            r_b_q    <= w_b_d;
            r_acc_q  <= w_acc_d;
            r_prod_q <= w_prod_d;
        end
    end

    assign out_prod = r_prod_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mul_seq
//  Description : Self-checking bench for booth_mul_seq (DW=8). Products are
//                compared against plain signed/unsigned multiplication.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mul_seq;

    localparam int DW = 8;
    localparam int K  = DW / 2 + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_signed = 1'b0;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*DW-1:0] out_prod;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    bit            sq_s[$];
    logic [DW-1:0] sq_a[$];
    logic [DW-1:0] sq_b[$];

    always #5 clk = ~clk;

    booth_mul_seq #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy)
    );

    function automatic logic [2*DW-1:0] model(input bit s, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic signed [2*DW-1:0] sa, sb;
        logic [2*DW-1:0]        ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {{DW{1'b0}}, a};
        ub = {{DW{1'b0}}, b};
        if (s) return sa * sb;
        return ua * ub;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_out_prod"},  out_prod,  0);
    endtask

    // Issue one operand pair and wait until its product is presented (out_ready low)
    task automatic transact(input bit s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            wait_edge();
            n++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        in_signed = s;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        wait_edge();
        in_valid  = 1'b0;
        // Operand changes after acceptance must not matter
        in_a      = DW'($urandom);
        in_b      = DW'($urandom);
        in_signed = 1'($urandom);
        n = 0;
        while (!out_valid && n < 4 * K) begin
            wait_edge();
            n++;
        end
        check({tag, "_lat"},  n,        K);
        check({tag, "_prod"}, out_prod, model(s, a, b));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        wait_edge();
        out_ready = 1'b0;
        check({tag, "_idle"},    in_ready,  1);
        check({tag, "_vld_low"}, out_valid, 0);
    endtask

    // Stream the queued operands with in_valid and out_ready held high.
    // Accepts land K RUN + 1 DONE + 1 IDLE cycles apart.
    task automatic stream(input string tag);
        logic [2*DW-1:0] exp_q[$];
        int total, sent, got, cyc, last_acc;
        bit acc;
        total    = sq_a.size();
        sent     = 0;
        got      = 0;
        cyc      = 0;
        last_acc = -1;
        out_ready = 1'b1;
        in_signed = sq_s[0];
        in_a      = sq_a[0];
        in_b      = sq_b[0];
        in_valid  = 1'b1;
        while (got < total && cyc < total * 12 + 50) begin
            acc = in_valid && in_ready;
            wait_edge();
            cyc++;
            if (acc) begin
                exp_q.push_back(model(sq_s[sent], sq_a[sent], sq_b[sent]));
                if (last_acc >= 0) check({tag, "_interval"}, cyc - last_acc, K + 2);
                last_acc = cyc;
                sent++;
                if (sent < total) begin
                    in_signed = sq_s[sent];
                    in_a      = sq_a[sent];
                    in_b      = sq_b[sent];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_spurious"}, 1, 0);
                end else begin
                    check({tag, "_prod"}, out_prod, exp_q.pop_front());
                end
                got++;
            end
        end
        check({tag, "_count"}, got, total);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sq_s.delete();
        sq_a.delete();
        sq_b.delete();
        wait_edge();
    endtask

    initial begin
        logic [DW-1:0]   grid[16];
        logic [2*DW-1:0] held;
        bit              seen_valid;

        grid = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h55, 8'h7E, 8'h7F,
                 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

        // Reset state
        rst = 1'b1;
        wait_edge();
        wait_edge();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed corner products with latency
        transact(1'b1, 8'h80, 8'h80, "s80x80");
        release_out("s80x80");
        transact(1'b0, 8'hFF, 8'hFF, "uFFxFF");
        release_out("uFFxFF");
        transact(1'b1, 8'hFF, 8'h01, "sFFx01");
        release_out("sFFx01");
        transact(1'b0, 8'hFF, 8'h01, "uFFx01");
        release_out("uFFx01");

        // Backpressure: product held for 10 cycles
        transact(1'b1, 8'd7, 8'hFD, "bp");
        check("bp_value", out_prod, 16'hFFEB);
        for (int i = 0; i < 10; i++) begin
            wait_edge();
            check("bp_valid", out_valid, 1);
            check("bp_stable", out_prod, 16'hFFEB);
            check("bp_in_ready", in_ready, 0);
        end
        release_out("bp");

        // Flush two groups into a transaction
        held = out_prod;
        in_signed = 1'b0;
        in_a      = 8'h55;
        in_b      = 8'h33;
        in_valid  = 1'b1;
        wait_edge();
        in_valid  = 1'b0;
        wait_edge();
        wait_edge();
        flush = 1'b1;
        in_valid = 1'b1;
        wait_edge();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", in_ready, 1);
        check("flush_busy", busy, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < K + 2; i++) begin
            if (out_valid) seen_valid = 1'b1;
            wait_edge();
        end
        check("flush_no_valid", seen_valid, 0);
        check("flush_prod_held", out_prod, held);
        transact(1'b0, 8'd3, 8'd4, "after_flush");
        release_out("after_flush");

        // Reset mid-RUN
        in_a = 8'h12;
        in_b = 8'h34;
        in_valid = 1'b1;
        wait_edge();
        in_valid = 1'b0;
        wait_edge();
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        check_reset_outputs("rst_run");

        // Reset during DONE
        transact(1'b1, 8'h9A, 8'h3C, "pre_rst");
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        check_reset_outputs("rst_done");

        // Back-to-back random pairs, mixed signedness
        for (int i = 0; i < 100; i++) begin
            sq_s.push_back(1'($urandom));
            sq_a.push_back(DW'($urandom));
            sq_b.push_back(DW'($urandom));
        end
        stream("rand");

        // Corner-value sweep, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    sq_s.push_back(m[0]);
                    sq_a.push_back(grid[i]);
                    sq_b.push_back(grid[j]);
                end
            end
        end
        stream("sweep");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
